// File: rtl/boid_frame_writer.sv
// Framebuffer writer for the boid display: on each frame boundary it erases the old
// boid squares, then fetches and plots the new ones. Optional macro: BOID_WRITER_OVERRUN_COUNT_EN.
module boid_frame_writer #(
    parameter int NUM_BOIDS           = 16,
    parameter int BOX_SIZE            = 2,
    parameter int VIDEO_WIDTH         = 640,
    parameter int VIDEO_HEIGHT        = 480,
    parameter int PIXEL_ADDRESS_WIDTH = 20,
    parameter int IDX_W               = $clog2(NUM_BOIDS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           screenEnd,
    output logic [IDX_W-1:0]               pos_read_index,
    input  logic [9:0]                     pos_read_x,
    input  logic [8:0]                     pos_read_y,
    output logic [PIXEL_ADDRESS_WIDTH-1:0] fb_write_address,
    output logic                           fb_write_data,
    output logic                           fb_write_en,
    output logic                           busy,
    output logic                           frame_done,
    output logic [7:0]                     overrun_count
);

    localparam int BOX_W = (BOX_SIZE > 1) ? $clog2(BOX_SIZE) : 1;
    localparam int PAW   = PIXEL_ADDRESS_WIDTH;
    localparam logic [BOX_W-1:0] BOX_MAX  = BOX_W'(BOX_SIZE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BOIDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ERASE, S_FETCH, S_LATCH, S_DRAW, S_DONE
    } state_t;

    state_t             r_state;
    logic               r_se_prev;
    logic [IDX_W-1:0]   r_idx;
    logic [BOX_W-1:0]   r_dx;
    logic [BOX_W-1:0]   r_dy;
    logic [9:0]         r_wx;
    logic [8:0]         r_wy;
    logic [9:0]         r_sx [NUM_BOIDS];
    logic [8:0]         r_sy [NUM_BOIDS];
    logic [NUM_BOIDS-1:0] r_sv;

    logic [IDX_W-1:0]   r_pos_idx;
    logic [PAW-1:0]     r_addr;
    logic               r_data;
    logic               r_en;
    logic               r_busy;
    logic               r_done;

    logic               w_start;
    logic               w_first_ok;
    logic [IDX_W-1:0]   w_first_idx;
    logic               w_next_ok;
    logic [IDX_W-1:0]   w_next_idx;
    logic               w_box_last;
    logic [BOX_W-1:0]   w_dx_step;
    logic [BOX_W-1:0]   w_dy_step;
    state_t             w_n_state;
    logic [IDX_W-1:0]   w_n_idx;
    logic [BOX_W-1:0]   w_n_dx;
    logic [BOX_W-1:0]   w_n_dy;
    logic [9:0]         w_base_x;
    logic [8:0]         w_base_y;
    logic [10:0]        w_px;
    logic [9:0]         w_py;
    logic               w_clip;
    logic [PAW-1:0]     w_addr;

    assign w_start = screenEnd & ~r_se_prev;

    // Lowest valid shadow overall, and lowest valid shadow after the boid being erased.
    always_comb begin
        w_first_ok  = 1'b0;
        w_first_idx = {IDX_W{1'b0}};
        w_next_ok   = 1'b0;
        w_next_idx  = {IDX_W{1'b0}};
        for (int k = NUM_BOIDS - 1; k >= 0; k--) begin
            w_first_ok  = r_sv[k] ? 1'b1 : w_first_ok;
            w_first_idx = r_sv[k] ? IDX_W'(k) : w_first_idx;
            w_next_ok   = (r_sv[k] && (k > int'(r_idx))) ? 1'b1 : w_next_ok;
            w_next_idx  = (r_sv[k] && (k > int'(r_idx))) ? IDX_W'(k) : w_next_idx;
        end
    end

    // Next-cycle state, scan position and the pixel that cycle will write.
    always_comb begin
        w_box_last = (r_dx == BOX_MAX) && (r_dy == BOX_MAX);
        w_dx_step  = (r_dx == BOX_MAX) ? {BOX_W{1'b0}} : r_dx + BOX_W'(1);
        w_dy_step  = (r_dx != BOX_MAX) ? r_dy :
                     ((r_dy == BOX_MAX) ? {BOX_W{1'b0}} : r_dy + BOX_W'(1));
        w_n_state  = r_state;
        w_n_idx    = r_idx;
        w_n_dx     = r_dx;
        w_n_dy     = r_dy;
        case (r_state)
            S_IDLE: begin
                w_n_dx = {BOX_W{1'b0}};
                w_n_dy = {BOX_W{1'b0}};
                if (w_start && w_first_ok) begin
                    w_n_state = S_ERASE;
                    w_n_idx   = w_first_idx;
                end else if (w_start) begin
                    w_n_state = S_FETCH;
                    w_n_idx   = {IDX_W{1'b0}};
                end else begin
                    w_n_state = S_IDLE;
                end
            end
            S_ERASE: begin
                w_n_dx = w_dx_step;
                w_n_dy = w_dy_step;
                if (w_box_last && w_next_ok) begin
                    w_n_idx = w_next_idx;
                end else if (w_box_last) begin
                    w_n_state = S_FETCH;
                    w_n_idx   = {IDX_W{1'b0}};
                end else begin
                    w_n_state = S_ERASE;
                end
            end
            S_FETCH: w_n_state = S_LATCH;
            S_LATCH: begin
                w_n_state = S_DRAW;
                w_n_dx    = {BOX_W{1'b0}};
                w_n_dy    = {BOX_W{1'b0}};
            end
            S_DRAW: begin
                w_n_dx = w_dx_step;
                w_n_dy = w_dy_step;
                if (w_box_last && (r_idx == LAST_IDX)) begin
                    w_n_state = S_DONE;
                end else if (w_box_last) begin
                    w_n_state = S_FETCH;
                    w_n_idx   = r_idx + IDX_W'(1);
                end else begin
                    w_n_state = S_DRAW;
                end
            end
            S_DONE:  w_n_state = S_IDLE;
            default: w_n_state = S_IDLE;
        endcase

        // The first DRAW cycle is computed while the position memory output is still live.
        if (w_n_state == S_ERASE) begin
            w_base_x = r_sx[w_n_idx];
            w_base_y = r_sy[w_n_idx];
        end else if (r_state == S_LATCH) begin
            w_base_x = pos_read_x;
            w_base_y = pos_read_y;
        end else begin
            w_base_x = r_wx;
            w_base_y = r_wy;
        end
        w_px   = 11'(w_base_x) + 11'(w_n_dx);
        w_py   = 10'(w_base_y) + 10'(w_n_dy);
        w_clip = (w_px >= 11'(VIDEO_WIDTH)) || (w_py >= 10'(VIDEO_HEIGHT));
        w_addr = PAW'(w_px) + PAW'(w_py) * PAW'(VIDEO_WIDTH);
    end

    // FSM, shadow store and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_se_prev <= 1'b0;
            r_idx     <= {IDX_W{1'b0}};
            r_dx      <= {BOX_W{1'b0}};
            r_dy      <= {BOX_W{1'b0}};
            r_wx      <= 10'd0;
            r_wy      <= 9'd0;
            r_sv      <= {NUM_BOIDS{1'b0}};
            for (int k = 0; k < NUM_BOIDS; k++) begin
                r_sx[k] <= 10'd0;
                r_sy[k] <= 9'd0;
            end
            r_pos_idx <= {IDX_W{1'b0}};
            r_addr    <= {PAW{1'b0}};
            r_data    <= 1'b0;
            r_en      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_se_prev <= screenEnd;
            r_state   <= w_n_state;
            r_idx     <= w_n_idx;
            r_dx      <= w_n_dx;
            r_dy      <= w_n_dy;
            if (r_state == S_LATCH) begin
                r_wx <= pos_read_x;
                r_wy <= pos_read_y;
            end
            if ((r_state == S_DRAW) && w_box_last) begin
                r_sx[r_idx] <= r_wx;
                r_sy[r_idx] <= r_wy;
                r_sv[r_idx] <= 1'b1;
            end
            r_pos_idx <= (w_n_state == S_FETCH) ? w_n_idx : {IDX_W{1'b0}};
            r_addr    <= w_addr;
            r_data    <= (w_n_state == S_DRAW);
            r_en      <= ((w_n_state == S_ERASE) || (w_n_state == S_DRAW)) && !w_clip;
            r_busy    <= (w_n_state != S_IDLE);
            r_done    <= (w_n_state == S_DONE);
        end
    end

    assign pos_read_index   = r_pos_idx;
    assign fb_write_address = r_addr;
    assign fb_write_data    = r_data;
    assign fb_write_en      = r_en;
    assign busy             = r_busy;
    assign frame_done       = r_done;

`ifdef BOID_WRITER_OVERRUN_COUNT_EN
    logic [7:0] r_overrun;

    // Counts frame triggers dropped because the previous frame was still in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overrun <= 8'd0;
        end else if (w_start && (r_state != S_IDLE) && (r_overrun != 8'd255)) begin
            r_overrun <= r_overrun + 8'd1;
        end
    end

    assign overrun_count = r_overrun;
`else
    assign overrun_count = 8'd0;
`endif

endmodule

// File: tb/tb_boid_frame_writer.sv
// Scoreboard bench for boid_frame_writer: a bench-side model queues every expected
// framebuffer write, and a monitor pops and compares each strobe the DUT issues.
module tb_boid_frame_writer;

    localparam int NB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        screenEnd = 1'b0;
    logic [3:0]  pos_read_index;
    logic [9:0]  pos_read_x = 10'd0;
    logic [8:0]  pos_read_y = 9'd0;
    logic [19:0] fb_write_address;
    logic        fb_write_data;
    logic        fb_write_en;
    logic        busy;
    logic        frame_done;
    logic [7:0]  overrun_count;

    typedef struct packed {
        logic [19:0] addr;
        logic        data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [9:0]  mem_x [NB];
    logic [8:0]  mem_y [NB];
    int          m_sx [NB];
    int          m_sy [NB];
    bit          m_valid [NB];
    bit          mon_en = 1'b1;
    int          n_checks = 0;
    int          n_fail = 0;

    boid_frame_writer dut (
        .clk              (clk),
        .reset            (reset),
        .screenEnd        (screenEnd),
        .pos_read_index   (pos_read_index),
        .pos_read_x       (pos_read_x),
        .pos_read_y       (pos_read_y),
        .fb_write_address (fb_write_address),
        .fb_write_data    (fb_write_data),
        .fb_write_en      (fb_write_en),
        .busy             (busy),
        .frame_done       (frame_done),
        .overrun_count    (overrun_count)
    );

    always #5 clk = ~clk;

    // Position memory with one clock of read latency.
    always @(posedge clk) begin
        pos_read_x <= mem_x[pos_read_index];
        pos_read_y <= mem_y[pos_read_index];
    end

    // Scoreboard monitor: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (mon_en && reset && fb_write_en) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=%0d, queue empty", fb_write_address, fb_write_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (fb_write_address !== mon_e.addr || fb_write_data !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL write_mismatch: got addr=%0d data=%0d, expected addr=%0d data=%0d",
                             fb_write_address, fb_write_data, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic push_px(input int x, input int y, input int dx, input int dy, input logic d);
        int px, py;
        px = x + dx;
        py = y + dy;
        if (px < 640 && py < 480) exp_q.push_back('{addr: 20'(px + 640 * py), data: d});
    endtask

    // Model one frame: erase every valid shadow, then draw every boid from memory.
    task automatic build_expect();
        for (int i = 0; i < NB; i++)
            if (m_valid[i])
                for (int dy = 0; dy < 2; dy++)
                    for (int dx = 0; dx < 2; dx++)
                        push_px(m_sx[i], m_sy[i], dx, dy, 1'b0);
        for (int i = 0; i < NB; i++) begin
            for (int dy = 0; dy < 2; dy++)
                for (int dx = 0; dx < 2; dx++)
                    push_px(int'(mem_x[i]), int'(mem_y[i]), dx, dy, 1'b1);
            m_valid[i] = 1'b1;
            m_sx[i] = int'(mem_x[i]);
            m_sy[i] = int'(mem_y[i]);
        end
    endtask

    // Pulse screenEnd (optionally a second pulse mid-frame) and time frame_done from the edge.
    task automatic run_frame(input string name, input int exp_len, input int hold,
                             input int second_at, input int limit);
        int k, done_at, dones;
        k = 0; done_at = 0; dones = 0;
        @(negedge clk);
        screenEnd = 1'b1;
        repeat (limit) begin
            @(negedge clk);
            k++;
            if (k == hold) screenEnd = 1'b0;
            if (second_at > 0 && k == second_at) screenEnd = 1'b1;
            if (second_at > 0 && k == second_at + 4) screenEnd = 1'b0;
            if (k == 1) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_busy_start: got %0b, expected 1", name, busy);
                end
            end
            if (frame_done === 1'b1) begin
                dones++;
                if (done_at == 0) done_at = k;
            end
        end
        n_checks++;
        if (done_at != exp_len) begin
            n_fail++;
            $display("FAIL %s_done_cycle: got %0d, expected %0d", name, done_at, exp_len);
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL %s_done_count: got %0d, expected 1", name, dones);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing_writes: got %0d left in queue, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy_end: got %0b, expected 0", name, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, frame_done, fb_write_en, fb_write_data} !== 4'b0000 ||
            fb_write_address !== 20'd0 || pos_read_index !== 4'd0 || overrun_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b en=%0b data=%0b addr=%0d idx=%0d ovr=%0d, expected all 0",
                     busy, frame_done, fb_write_en, fb_write_data, fb_write_address, pos_read_index, overrun_count);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy: got %0b, expected 0", busy);
        end
    endtask

    task automatic test_first_frame();
        mem_x[0] = 10'd100; mem_y[0] = 9'd50;
        for (int i = 1; i < NB; i++) begin
            mem_x[i] = 10'd700; mem_y[i] = 9'd500;
        end
        build_expect();
        run_frame("first", 97, 4, 0, 130);
    endtask

    task automatic test_move();
        mem_x[0] = 10'd101; mem_y[0] = 9'd50;
        build_expect();
        run_frame("move", 161, 4, 0, 200);
    endtask

    task automatic test_clip();
        mem_x[0] = 10'd639; mem_y[0] = 9'd479;
        build_expect();
        run_frame("clip", 161, 4, 0, 200);
    endtask

    task automatic test_overrun();
        int exp_ovr;
`ifdef BOID_WRITER_OVERRUN_COUNT_EN
        exp_ovr = 1;
`else
        exp_ovr = 0;
`endif
        build_expect();
        run_frame("overrun", 161, 4, 20, 200);
        n_checks++;
        if (int'(overrun_count) != exp_ovr) begin
            n_fail++;
            $display("FAIL overrun_count: got %0d, expected %0d", overrun_count, exp_ovr);
        end
    endtask

    task automatic test_reset_mid_draw();
        for (int i = 1; i < NB; i++) begin
            mem_x[i] = 10'(40 * i); mem_y[i] = 9'(30 * i);
        end
        build_expect();
        @(negedge clk);
        screenEnd = 1'b1;
        for (int k = 1; k <= 98; k++) begin
            @(negedge clk);
            if (k == 4) screenEnd = 1'b0;
        end
        n_checks++;
        if (fb_write_en !== 1'b1 || fb_write_data !== 1'b1 ||
            fb_write_address !== 20'(int'(mem_x[5]) + 1 + 640 * int'(mem_y[5]))) begin
            n_fail++;
            $display("FAIL mid_draw_boid5: got en=%0b data=%0b addr=%0d, expected en=1 data=1 addr=%0d",
                     fb_write_en, fb_write_data, fb_write_address, int'(mem_x[5]) + 1 + 640 * int'(mem_y[5]));
        end
        #2;
        mon_en = 1'b0;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({busy, frame_done, fb_write_en, fb_write_data} !== 4'b0000 ||
            fb_write_address !== 20'd0 || pos_read_index !== 4'd0 || overrun_count !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got busy=%0b done=%0b en=%0b data=%0b addr=%0d idx=%0d ovr=%0d, expected all 0",
                     busy, frame_done, fb_write_en, fb_write_data, fb_write_address, pos_read_index, overrun_count);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NB; i++) m_valid[i] = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        build_expect();
        run_frame("after_reset", 97, 4, 0, 130);
    endtask

    task automatic test_held_high();
        build_expect();
        run_frame("held_high", 161, 100, 0, 300);
    endtask

    initial begin
        for (int i = 0; i < NB; i++) begin
            mem_x[i] = 10'd0; mem_y[i] = 9'd0;
            m_sx[i] = 0; m_sy[i] = 0; m_valid[i] = 1'b0;
        end
        test_reset();
        test_first_frame();
        test_move();
        test_clip();
        test_overrun();
        test_reset_mid_draw();
        test_held_high();
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/boid_frame_writer.md
Name: boid_frame_writer

Overview:
- Writer side of the 1-bit boid framebuffer that the VGA controller scans out through its read port.
- On each frame boundary (rising edge of screenEnd), erases every boid's previous footprint. It then fetches each boid's new (x,y) from the boid position memory and plots a BOX_SIZE x BOX_SIZE square of 1s.
- Runs in the 100 MHz domain, inside vertical blanking, so scan-out never sees a half-drawn frame.

Parameters:
- NUM_BOIDS, 16, boids drawn per frame; IDX_W = $clog2(NUM_BOIDS).
- BOX_SIZE, 2, side length in pixels of each boid square.
- VIDEO_WIDTH, 640, screen width; also the row stride of the address.
- VIDEO_HEIGHT, 480, screen height.
- PIXEL_ADDRESS_WIDTH, 20, framebuffer address width.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  Asynchronous, active-low reset.
- screenEnd  in  1  Frame-boundary flag from the timing generator; high for one 25 MHz period (4 clk cycles).
- pos_read_index  out  IDX_W  Boid index presented to the position memory.
- pos_read_x  in  10  Boid x; valid 1 clk after pos_read_index.
- pos_read_y  in  9  Boid y; valid 1 clk after pos_read_index.
- fb_write_address  out  PIXEL_ADDRESS_WIDTH  Framebuffer write address = x + VIDEO_WIDTH*y.
- fb_write_data  out  1  Pixel value: 1 = boid, 0 = background.
- fb_write_en  out  1  Framebuffer write strobe, one pixel per clk.
- busy  out  1  High while erasing or drawing.
- frame_done  out  1  One-cycle pulse when the frame update completes.
- overrun_count  out  8  Dropped frame triggers (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; state IDLE; internal counters 0; all shadow-valid bits cleared. The framebuffer contents are not cleared, so stale pixels may remain after a mid-frame reset.
- Start: screenEnd is registered each clk. A start edge is a cycle N with screenEnd=1 and previous sample=0. In IDLE a start edge moves the FSM to ERASE; busy=1 and the first write both occur at cycle N+1.
- Shadow storage: per boid, the last drawn x (10b), y (9b) and a valid bit.
- FSM states:
  - IDLE: waits for a start edge.
  - ERASE: for boid i = 0..NUM_BOIDS-1 with shadow valid, issue BOX_SIZE^2 writes of 0 at (sx+dx, sy+dy), dx inner loop, dy outer, 0..BOX_SIZE-1. Boids with valid=0 are skipped in 0 cycles. After the last boid, go to FETCH with i=0.
  - FETCH: drive pos_read_index=i for 1 cycle, then go to LATCH.
  - LATCH: capture pos_read_x/pos_read_y into working regs, then go to DRAW.
  - DRAW: issue BOX_SIZE^2 writes of 1 in the same scan order, and store the position into shadow[i] with valid=1. If i<NUM_BOIDS-1, increment i and go to FETCH; otherwise go to DONE.
  - DONE: frame_done=1 for 1 cycle, busy=0 from the next cycle, return to IDLE.
- Ordering: all erases complete before any draw, so overlapping boids are never erased by a later boid.
- Frame timing:
  - With all shadows valid, a frame takes NUM_BOIDS*BOX_SIZE^2 + NUM_BOIDS*(2+BOX_SIZE^2) cycles, plus 1 cycle in DONE. Defaults: 64+96+1 = 161 cycles.
  - First frame after reset: 97 cycles.
- Pixel arithmetic: px = x+dx (11b), py = y+dy (10b). Clipping applies when px >= VIDEO_WIDTH or py >= VIDEO_HEIGHT:
  - fb_write_en=0 for that cycle;
  - the scan counters still advance, so timing is position-independent;
  - the address is still computed and is don't-care.
- fb_write_en=0 in IDLE, FETCH, LATCH and DONE.
- A start edge arriving while busy is ignored; the current frame completes normally.
- A start edge in the same cycle as DONE is ignored, because the FSM is not yet in IDLE.

Optional Feature:
- Macro: BOID_WRITER_OVERRUN_COUNT_EN.
- Defined: overrun_count increments by 1 on each start edge ignored while not in IDLE. It saturates at 255 and clears only on reset.
- Undefined: the port is present and tied to 0; no counter logic is built.

Test Plan:
- Reset, then one screenEnd pulse (4 clk high) with boid 0 at (100,50), all others at (700,500), NUM_BOIDS=16, BOX_SIZE=2 -> no ERASE writes. Exactly 4 writes with data=1, at addresses 32100, 32101, 32740, 32741. frame_done arrives 97 cycles after the edge; all other boids produce 0 write strobes.
- Second pulse with boid 0 moved to (101,50) -> 4 writes of 0 at the old addresses, all before any data=1 write, then 1s at 32101, 32102, 32741, 32742. frame_done arrives 161 cycles after the edge.
- Boid at (639,479) -> only address 639+640*479 = 307199 is written; the 3 clipped pixels produce no strobe; frame length is unchanged.
- Second screenEnd edge 20 cycles into a frame -> ignored, frame_done still at the expected cycle. With the macro defined overrun_count=1; without it, overrun_count=0.
- reset asserted during DRAW of boid 5, released, then a new edge -> outputs 0 immediately on assertion. The next frame performs no ERASE writes because all shadow-valid bits were cleared.
- screenEnd held high for 100 cycles -> exactly one frame starts (edge-triggered).
